// File: rtl/frog_key_cmd.sv
// Turns PS/2 extended arrow-key bytes into one-hot hop commands for the frog movement block.
// Optional build macro FROG_KEY_AUTO_REPEAT_EN: a still-held key restarts its hop after each one ends.
module frog_key_cmd #(
   parameter int unsigned HOP_TICKS = 8,
   parameter logic [7:0]  KEY_UP    = 8'h75,
   parameter logic [7:0]  KEY_DOWN  = 8'h72,
   parameter logic [7:0]  KEY_LEFT  = 8'h6B,
   parameter logic [7:0]  KEY_RIGHT = 8'h74
) (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic [7:0] din,
   input  logic       din_new,
   input  logic       timer_done,
   input  logic       reset_position,
   output logic       left,
   output logic       right,
   output logic       up,
   output logic       down,
   output logic       busy,
   output logic [3:0] held
);

   typedef enum logic [1:0] {P_IDLE, P_EXT, P_EXT_BRK, P_BRK} parse_t;
   typedef enum logic {H_IDLE, H_HOP} hop_t;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;
   localparam logic [7:0] HOP_LOAD = 8'(HOP_TICKS);

   parse_t     p_q, p_d;
   hop_t       h_q, h_d;
   logic [7:0] count_q, count_d;
   logic [3:0] dir_q, dir_d;
   logic [3:0] pend_q, pend_d;
   logic       pend_vld_q, pend_vld_d;
   logic [3:0] held_q, held_d;
   logic [3:0] key_oh;
   logic       make_ev;

   // Direction vectors use the held ordering {up,down,left,right}.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      key_oh = 4'b0000;
      case (din)
         KEY_UP:    key_oh = 4'b1000;
         KEY_DOWN:  key_oh = 4'b0100;
         KEY_LEFT:  key_oh = 4'b0010;
         KEY_RIGHT: key_oh = 4'b0001;
         default:   key_oh = 4'b0000;
      endcase
   end

   always_comb begin
      p_d     = p_q;
      held_d  = held_q;
      make_ev = 1'b0;
      if (din_new) begin
         case (p_q)
            P_IDLE: begin
               if (din == CODE_EXT)      p_d = P_EXT;
               else if (din == CODE_BRK) p_d = P_BRK;
            end
            P_EXT: begin
               if (din == CODE_BRK)      p_d = P_EXT_BRK;
               else if (din != CODE_EXT) begin
                  p_d = P_IDLE;
                  // A make on an already-held key is typematic repeat and is dropped.
                  if (key_oh != 4'b0000 && (held_q & key_oh) == 4'b0000) begin
                     held_d  = held_q | key_oh;
                     make_ev = 1'b1;
                  end
               end
            end
            P_EXT_BRK: begin
               p_d    = P_IDLE;
               held_d = held_q & ~key_oh;
            end
            default: p_d = P_IDLE;
         endcase
      end
      if (reset_position) begin
         p_d     = P_IDLE;
         held_d  = 4'b0000;
         make_ev = 1'b0;
      end
   end

   always_comb begin
      h_d        = h_q;
      count_d    = count_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      case (h_q)
         H_IDLE: begin
            // A pending make starts here, which leaves the one all-zero cycle between hops.
            if (make_ev) begin
               dir_d      = key_oh;
               count_d    = HOP_LOAD;
               h_d        = H_HOP;
               pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
               dir_d      = pend_q;
               count_d    = HOP_LOAD;
               h_d        = H_HOP;
               pend_vld_d = 1'b0;
            end
         end
         default: begin
            if (make_ev) begin
               pend_d     = key_oh;
               pend_vld_d = 1'b1;
            end
            if (timer_done) begin
               if (count_q == 8'd1) begin
                  h_d     = H_IDLE;
                  count_d = 8'd0;
`ifdef FROG_KEY_AUTO_REPEAT_EN
                  if (!make_ev && !pend_vld_q && (held_d & dir_q) != 4'b0000) begin
                     pend_d     = dir_q;
                     pend_vld_d = 1'b1;
                  end
`endif
               end else begin
                  count_d = count_q - 8'd1;
               end
            end
         end
      endcase
      if (reset_position) begin
         h_d        = H_IDLE;
         count_d    = 8'd0;
         pend_vld_d = 1'b0;
         pend_d     = 4'b0000;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         p_q        <= P_IDLE;
         h_q        <= H_IDLE;
         count_q    <= 8'd0;
         dir_q      <= 4'b0000;
         pend_q     <= 4'b0000;
         pend_vld_q <= 1'b0;
         held_q     <= 4'b0000;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         p_q        <= p_d;
         h_q        <= h_d;
         count_q    <= count_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         held_q     <= held_d;
      end
   end

   assign busy                     = (h_q == H_HOP);
   assign {up, down, left, right}  = busy ? dir_q : 4'b0000;
   assign held                     = held_q;

endmodule

// File: tb/tb_frog_key_cmd.sv
// Self-checking bench for frog_key_cmd: directed test-plan steps plus random byte/tick traffic,
// every cycle compared against a key-event level reference model.
module tb_frog_key_cmd;

   localparam int HOP = 8;

   logic       CLK = 1'b0;
   logic       RESETn = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_new = 1'b0;
   logic       timer_done = 1'b0;
   logic       reset_position = 1'b0;
   logic       left, right, up, down, busy;
   logic [3:0] held;

   int n_tests = 0;
   int n_fail  = 0;

   frog_key_cmd dut (
      .CLK(CLK), .RESETn(RESETn), .din(din), .din_new(din_new),
      .timer_done(timer_done), .reset_position(reset_position),
      .left(left), .right(right), .up(up), .down(down),
      .busy(busy), .held(held)
   );

   always #5 CLK = ~CLK;

   // Reference model: key index 0=up 1=down 2=left 3=right; m_left = ticks still to run (0 = idle).
   bit m_ext, m_brk;
   bit m_held[4];
   int m_left, m_dir, m_pend;

   function automatic int key_idx(input logic [7:0] b);
      case (b)
         8'h75:   return 0;
         8'h72:   return 1;
         8'h6B:   return 2;
         8'h74:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_held = '{default: 0};
      m_left = 0; m_dir = 0; m_pend = -1;
   endtask

   task automatic model_step(input logic dn, input logic [7:0] b, input logic td, input logic rp);
      int k;
      int mk;
      mk = -1;
      if (rp) begin
         m_ext = 0; m_brk = 0; m_held = '{default: 0}; m_left = 0; m_pend = -1;
         return;
      end
      if (dn) begin
         k = key_idx(b);
         if (m_brk) begin
            if (m_ext && k >= 0) m_held[k] = 0;
            m_ext = 0; m_brk = 0;
         end else if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            if (m_ext && k >= 0 && !m_held[k]) begin
               m_held[k] = 1; mk = k;
            end
            m_ext = 0;
         end
      end
      if (m_left == 0) begin
         if (mk >= 0) begin m_dir = mk; m_left = HOP; m_pend = -1; end
         else if (m_pend >= 0) begin m_dir = m_pend; m_left = HOP; m_pend = -1; end
      end else begin
         if (mk >= 0) m_pend = mk;
         if (td) begin
            m_left--;
`ifdef FROG_KEY_AUTO_REPEAT_EN
            if (m_left == 0 && m_pend < 0 && m_held[m_dir]) m_pend = m_dir;
`endif
         end
      end
   endtask

   function automatic logic [8:0] model_out();
      logic [3:0] d;
      d = 4'b0000;
      if (m_left > 0) d[3 - m_dir] = 1'b1;
      return {d, (m_left > 0), m_held[0], m_held[1], m_held[2], m_held[3]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, compare at the falling edge, advance the model on the rising edge.
   task automatic cycle(input logic dn, input logic [7:0] b, input logic td, input logic rp);
      din_new = dn; din = b; timer_done = td; reset_position = rp;
      @(negedge CLK);
      chk("outputs", {up, down, left, right, busy, held}, model_out());
      @(posedge CLK);
      model_step(dn, b, td, rp);
      #1;
      din_new = 1'b0; timer_done = 1'b0; reset_position = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h11};

   initial begin
      model_reset();
      #2;
      chk("reset_outputs", {up, down, left, right, busy, held}, 9'h000);
      @(negedge CLK);
      RESETn = 1'b1;
      @(posedge CLK);
      #1;

      // Single up hop: exactly HOP ticks, key held until break.
      send(8'hE0); send(8'h75);
      chk("t1_up_start", {up, busy, held}, 6'b11_1000);
      ticks(HOP - 1);
      chk("t1_up_tick7", up, 1'b1);
      ticks(1);
      chk("t1_up_dropped", {up, down, left, right, busy}, 5'b0);
      chk("t1_held_kept", held, 4'b1000);
      send(8'hE0); send(8'hF0); send(8'h75);
      ticks(HOP); idle(2);
      chk("t1_held_released", held, 4'b0000);

      // Left hop with right queued mid-hop; one zero cycle between them.
      send(8'hE0); send(8'h6B);
      ticks(3);
      send(8'hE0); send(8'hF0); send(8'h6B); send(8'hE0); send(8'h74);
      chk("t2_left_survives_break", left, 1'b1);
      ticks(HOP - 3);
      chk("t2_gap_cycle", {up, down, left, right, busy}, 5'b0);
      idle(1);
      chk("t2_right_start", {right, busy}, 2'b11);
      ticks(HOP - 1);
      send(8'hE0); send(8'hF0); send(8'h74);
      ticks(1);
      chk("t2_right_end", {right, busy}, 2'b00);
      idle(3);

      // Typematic repeats during a hop create no pending hop.
      send(8'hE0); send(8'h75);
      ticks(2);
      for (int i = 0; i < 5; i++) begin send(8'hE0); send(8'h75); end
      ticks(HOP - 2);
      chk("t3_hop_end", {up, busy}, 2'b00);
      idle(1);
`ifdef FROG_KEY_AUTO_REPEAT_EN
      chk("t3_auto_restart", up, 1'b1);
`else
      chk("t3_no_repeat_hop", busy, 1'b0);
`endif
      send(8'hE0); send(8'hF0); send(8'h75);
      ticks(HOP); idle(3);
      chk("t3_quiet", {busy, held}, 5'b0);

      // Non-arrow and non-extended traffic produces nothing and leaves the parser idle.
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE0); send(8'h11);
      chk("t4_no_output", {up, down, left, right, busy, held}, 9'h000);
      send(8'hE0); send(8'h72);
      chk("t4_parser_idle_down", {down, busy, held}, 6'b11_0100);

      // reset_position mid-hop with a pending left discards everything.
      ticks(3);
      send(8'hE0); send(8'h6B);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t5_flush", {up, down, left, right, busy, held}, 9'h000);
      idle(HOP);
      chk("t5_no_hop_after", busy, 1'b0);

`ifdef FROG_KEY_AUTO_REPEAT_EN
      // Holding right walks in 8-tick hops with a one-cycle gap; a break lets the current hop finish.
      send(8'hE0); send(8'h74);
      ticks(HOP);
      chk("t6_gap", right, 1'b0);
      idle(1);
      chk("t6_restart", right, 1'b1);
      ticks(4);
      send(8'hE0); send(8'hF0); send(8'h74);
      chk("t6_break_mid_hop", right, 1'b1);
      ticks(HOP - 4);
      idle(3);
      chk("t6_stops", busy, 1'b0);
`endif

      // Random bytes, ticks and flushes against the model.
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 99) < 35), pool[$urandom_range(0, 7)],
               ($urandom_range(0, 99) < 30), ($urandom_range(0, 199) == 0));
      end

      // Asynchronous reset mid-run clears outputs without a clock edge.
      send(8'hE0); send(8'h72);
      #2;
      RESETn = 1'b0;
      #1;
      chk("async_reset", {up, down, left, right, busy, held}, 9'h000);
      model_reset();
      @(negedge CLK);
      RESETn = 1'b1;
      @(posedge CLK);
      #1;
      send(8'hE0); send(8'h6B);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
